// File: rtl/cash_rd_arbiter.sv
// cash_rd_arbiter: round-robin arbiter sharing the single cache read port
// between the IR decoder loader (requester 0) and the data load unit
// (requester 1). Grants bursts bounded by MAX_BURST and steers returned
// read data back to the requester that issued each read.
module cash_rd_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req0,
  input  logic [DATA_WIDTH-1:0] i_addr0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  input  logic                  i_req1,
  input  logic [DATA_WIDTH-1:0] i_addr1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic                  o_cash_ren,
  output logic [DATA_WIDTH-1:0] o_cash_addr,
  input  logic [DATA_WIDTH-1:0] i_cash_rdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_owner
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last;
  logic             last_nxt;
  logic             ret_v;
  logic             ret_id;
  logic             beat0;
  logic             beat1;
  logic             beat;
  logic             limit_hit;

  // Grants decode straight from the state register
  assign o_gnt0  = (state == GNT0);
  assign o_gnt1  = (state == GNT1);
  assign o_owner = (state == GNT1);

  // A beat is a granted cycle whose owner is still requesting
  assign beat0 = o_gnt0 & i_req0;
  assign beat1 = o_gnt1 & i_req1;
  assign beat  = beat0 | beat1;

  // True when this beat brings the burst count to (or keeps it at) the limit
  assign limit_hit = (cnt >= CNT_W'(MAX_BURST - 1));

  // Cache read port is driven only during a beat, zero otherwise
  assign o_cash_ren  = beat;
  assign o_cash_addr = beat1 ? i_addr1 : (beat0 ? i_addr0 : '0);

  // Returned data strobe goes to whichever requester issued the beat
  assign o_rvalid0 = ret_v & ~ret_id;
  assign o_rvalid1 = ret_v &  ret_id;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, round-robin pointer and burst counter update
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (i_req0 && i_req1) begin
          state_nxt = last ? GNT0 : GNT1;
        end else if (i_req0) begin
          state_nxt = GNT0;
        end else if (i_req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!i_req0) begin
          state_nxt = i_req1 ? GNT1 : IDLE;
        end else if (limit_hit && i_req1) begin
          state_nxt = GNT1;
        end
      end
      GNT1: begin
        if (!i_req1) begin
          state_nxt = i_req0 ? GNT0 : IDLE;
        end else if (limit_hit && i_req0) begin
          state_nxt = GNT0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt == GNT0) begin
        last_nxt = 1'b0;
      end else if (state_nxt == GNT1) begin
        last_nxt = 1'b1;
      end
    end else if (beat && (cnt != CNT_W'(MAX_BURST))) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Burst bookkeeping and read-return pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      last    <= 1'b1;
      ret_v   <= 1'b0;
      ret_id  <= 1'b0;
      o_rdata <= '0;
    end else begin
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      ret_v   <= beat;
      ret_id  <= beat1;
      o_rdata <= i_cash_rdata;
    end
  end

endmodule

// File: tb/tb_cash_rd_arbiter.sv
// tb_cash_rd_arbiter: scenario tasks with a return-data scoreboard queue.
module tb_cash_rd_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic          clk;
  logic          rst;
  logic          i_req0;
  logic [DW-1:0] i_addr0;
  logic          o_gnt0;
  logic          o_rvalid0;
  logic          i_req1;
  logic [DW-1:0] i_addr1;
  logic          o_gnt1;
  logic          o_rvalid1;
  logic          o_cash_ren;
  logic [DW-1:0] o_cash_addr;
  logic [DW-1:0] i_cash_rdata;
  logic [DW-1:0] o_rdata;
  logic          o_owner;

  typedef struct {
    logic          id;
    logic [DW-1:0] d;
    int            cyc;
  } ret_t;

  ret_t          exp_q[$];
  int            n_pass;
  int            n_total;
  int            cyc;
  int            left0, left1, done0, done1;
  logic          en0, en1;
  logic [DW-1:0] base0, base1;

  cash_rd_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_req0       (i_req0),
    .i_addr0      (i_addr0),
    .o_gnt0       (o_gnt0),
    .o_rvalid0    (o_rvalid0),
    .i_req1       (i_req1),
    .i_addr1      (i_addr1),
    .o_gnt1       (o_gnt1),
    .o_rvalid1    (o_rvalid1),
    .o_cash_ren   (o_cash_ren),
    .o_cash_addr  (o_cash_addr),
    .i_cash_rdata (i_cash_rdata),
    .o_rdata      (o_rdata),
    .o_owner      (o_owner)
  );

  // Cache model: data for an address is that address plus 0x80
  assign i_cash_rdata = o_cash_ren ? o_cash_addr + 8'h80 : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start a scenario: requester budgets and base addresses
  task automatic setup(input int l0, input int l1, input logic [DW-1:0] b0,
                       input logic [DW-1:0] b1, input logic e0, input logic e1);
    left0 = l0; left1 = l1; done0 = 0; done1 = 0;
    base0 = b0; base1 = b1; en0 = e0; en1 = e1;
  endtask

  // One clock: requesters drive after the edge, outputs sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    i_req0  = en0 && (left0 > 0);
    i_addr0 = base0 + 8'(done0);
    i_req1  = en1 && (left1 > 0);
    i_addr1 = base1 + 8'(done1);
    @(negedge clk);
    if (o_gnt0 && i_req0) begin done0++; left0--; end
    if (o_gnt1 && i_req1) begin done1++; left1--; end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren, o_owner} !== 6'b0)
      $display("FAIL reset_flags gnt0/gnt1/rv0/rv1/ren/owner=%b%b%b%b%b%b want 000000",
               o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren, o_owner);
    else n_pass++;
    n_total++;
    if (o_cash_addr !== 8'h00 || o_rdata !== 8'h00)
      $display("FAIL reset_buses addr=%h rdata=%h want 00/00", o_cash_addr, o_rdata);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren} !== 5'b0)
      $display("FAIL post_reset_idle gnt0/gnt1/rv0/rv1/ren=%b%b%b%b%b want 00000",
               o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren);
    else n_pass++;
  endtask

  task automatic test_single();
    logic eg0, eg1, eb, eid, erv0, erv1;
    logic [DW-1:0] ea, ed;
    ret_t r;
    setup(5, 0, 8'h10, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c <= 8; c++) begin
      tick();
      eg0 = (c >= 1 && c <= 6); eg1 = 1'b0;
      eb  = (c >= 1 && c <= 5); eid = 1'b0;
      ea  = eb ? 8'h10 + 8'(c - 1) : 8'h00;
      n_total++;
      if (o_gnt0 !== eg0 || o_gnt1 !== eg1 || o_cash_ren !== eb || o_cash_addr !== ea ||
          ((eg0 || eg1) && o_owner !== eg1))
        $display("FAIL single_port c=%0d gnt=%b%b ren=%b addr=%h owner=%b want gnt=%b%b ren=%b addr=%h",
                 c, o_gnt0, o_gnt1, o_cash_ren, o_cash_addr, o_owner, eg0, eg1, eb, ea);
      else n_pass++;
      erv0 = 1'b0; erv1 = 1'b0; ed = 8'h00;
      if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
        r = exp_q.pop_front(); erv0 = ~r.id; erv1 = r.id; ed = r.d;
      end
      n_total++;
      if (o_rvalid0 !== erv0 || o_rvalid1 !== erv1 || ((erv0 || erv1) && o_rdata !== ed))
        $display("FAIL single_ret c=%0d rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                 c, o_rvalid0, o_rvalid1, o_rdata, erv0, erv1, ed);
      else n_pass++;
      if (eb) exp_q.push_back('{eid, ea + 8'h80, cyc});
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL single_drain pending=%0d want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    logic eg0, eg1, eb, eid, erv0, erv1;
    logic [DW-1:0] ea, ed;
    ret_t r;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    setup(3, 3, 8'h20, 8'h40, 1'b1, 1'b1);
    for (int c = 0; c <= 10; c++) begin
      tick();
      eg0 = (c >= 1 && c <= 4); eg1 = (c >= 5 && c <= 8);
      eb  = (c >= 1 && c <= 3) || (c >= 5 && c <= 7); eid = (c >= 5);
      ea  = !eb ? 8'h00 : (eid ? 8'h40 + 8'(c - 5) : 8'h20 + 8'(c - 1));
      n_total++;
      if (o_gnt0 !== eg0 || o_gnt1 !== eg1 || o_cash_ren !== eb || o_cash_addr !== ea ||
          ((eg0 || eg1) && o_owner !== eg1))
        $display("FAIL simul_port c=%0d gnt=%b%b ren=%b addr=%h owner=%b want gnt=%b%b ren=%b addr=%h",
                 c, o_gnt0, o_gnt1, o_cash_ren, o_cash_addr, o_owner, eg0, eg1, eb, ea);
      else n_pass++;
      erv0 = 1'b0; erv1 = 1'b0; ed = 8'h00;
      if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
        r = exp_q.pop_front(); erv0 = ~r.id; erv1 = r.id; ed = r.d;
      end
      n_total++;
      if (o_rvalid0 !== erv0 || o_rvalid1 !== erv1 || ((erv0 || erv1) && o_rdata !== ed))
        $display("FAIL simul_ret c=%0d rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                 c, o_rvalid0, o_rvalid1, o_rdata, erv0, erv1, ed);
      else n_pass++;
      if (eb) exp_q.push_back('{eid, ea + 8'h80, cyc});
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL simul_drain pending=%0d want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_fairness();
    logic eg0, eg1, eb, eid, erv0, erv1;
    logic [DW-1:0] ea, ed;
    ret_t r;
    int k;
    setup(8, 8, 8'h00, 8'h80, 1'b1, 1'b1);
    for (int c = 0; c <= 19; c++) begin
      tick();
      k   = c - 1;
      eb  = (c >= 1 && c <= 16);
      eid = eb ? 1'((k / 4) % 2) : 1'b0;
      eg0 = eb && !eid;
      eg1 = (eb && eid) || (c == 17);
      ea  = !eb ? 8'h00 : ((eid ? 8'h80 : 8'h00) + 8'((k / 8) * 4 + k % 4));
      n_total++;
      if (o_gnt0 !== eg0 || o_gnt1 !== eg1 || o_cash_ren !== eb || o_cash_addr !== ea ||
          ((eg0 || eg1) && o_owner !== eg1))
        $display("FAIL fair_port c=%0d gnt=%b%b ren=%b addr=%h owner=%b want gnt=%b%b ren=%b addr=%h",
                 c, o_gnt0, o_gnt1, o_cash_ren, o_cash_addr, o_owner, eg0, eg1, eb, ea);
      else n_pass++;
      erv0 = 1'b0; erv1 = 1'b0; ed = 8'h00;
      if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
        r = exp_q.pop_front(); erv0 = ~r.id; erv1 = r.id; ed = r.d;
      end
      n_total++;
      if (o_rvalid0 !== erv0 || o_rvalid1 !== erv1 || ((erv0 || erv1) && o_rdata !== ed))
        $display("FAIL fair_ret c=%0d rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                 c, o_rvalid0, o_rvalid1, o_rdata, erv0, erv1, ed);
      else n_pass++;
      if (eb) exp_q.push_back('{eid, ea + 8'h80, cyc});
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL fair_drain pending=%0d want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_saturation();
    logic eg0, eg1, eb, eid, erv0, erv1;
    logic [DW-1:0] ea, ed;
    ret_t r;
    setup(2, 40, 8'hC0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c <= 45; c++) begin
      if (c == 30) en0 = 1'b1;
      tick();
      eg0 = (c >= 31 && c <= 33);
      eg1 = (c >= 1 && c <= 30) || (c >= 34 && c <= 44);
      eb  = (c >= 1 && c <= 32) || (c >= 34 && c <= 43);
      eid = !(c >= 31 && c <= 33);
      if (!eb)                  ea = 8'h00;
      else if (c <= 30)         ea = 8'(c - 1);
      else if (c <= 32)         ea = 8'hC0 + 8'(c - 31);
      else                      ea = 8'(30 + c - 34);
      n_total++;
      if (o_gnt0 !== eg0 || o_gnt1 !== eg1 || o_cash_ren !== eb || o_cash_addr !== ea ||
          ((eg0 || eg1) && o_owner !== eg1))
        $display("FAIL sat_port c=%0d gnt=%b%b ren=%b addr=%h owner=%b want gnt=%b%b ren=%b addr=%h",
                 c, o_gnt0, o_gnt1, o_cash_ren, o_cash_addr, o_owner, eg0, eg1, eb, ea);
      else n_pass++;
      erv0 = 1'b0; erv1 = 1'b0; ed = 8'h00;
      if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
        r = exp_q.pop_front(); erv0 = ~r.id; erv1 = r.id; ed = r.d;
      end
      n_total++;
      if (o_rvalid0 !== erv0 || o_rvalid1 !== erv1 || ((erv0 || erv1) && o_rdata !== ed))
        $display("FAIL sat_ret c=%0d rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                 c, o_rvalid0, o_rvalid1, o_rdata, erv0, erv1, ed);
      else n_pass++;
      if (eb) exp_q.push_back('{eid, ea + 8'h80, cyc});
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sat_drain pending=%0d want 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    setup(5, 5, 8'h50, 8'h60, 1'b0, 1'b1);
    tick();
    tick();
    n_total++;
    if (o_gnt1 !== 1'b1 || o_cash_ren !== 1'b1 || o_cash_addr !== 8'h60)
      $display("FAIL rmb_first_beat gnt1=%b ren=%b addr=%h want 1/1/60", o_gnt1, o_cash_ren, o_cash_addr);
    else n_pass++;
    tick();
    n_total++;
    if (o_rvalid1 !== 1'b1 || o_rdata !== 8'hE0 || o_cash_addr !== 8'h61)
      $display("FAIL rmb_second_beat rv1=%b rdata=%h addr=%h want 1/e0/61", o_rvalid1, o_rdata, o_cash_addr);
    else n_pass++;
    // Reset lands in the cycle whose strobe would return the 0x61 read
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren, o_owner} !== 6'b0 ||
        o_cash_addr !== 8'h00 || o_rdata !== 8'h00)
      $display("FAIL rmb_reset_outputs gnt=%b%b rv=%b%b ren=%b owner=%b addr=%h rdata=%h want all 0",
               o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren, o_owner, o_cash_addr, o_rdata);
    else n_pass++;
    @(posedge clk);
    #1;
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    rst    = 1'b0;
    setup(1, 1, 8'h70, 8'h78, 1'b1, 1'b1);
    tick();
    n_total++;
    if ({o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren} !== 5'b0)
      $display("FAIL rmb_after_release gnt=%b%b rv=%b%b ren=%b want 00/00/0",
               o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_cash_ren);
    else n_pass++;
    tick();
    n_total++;
    if (o_gnt0 !== 1'b1 || o_gnt1 !== 1'b0 || o_cash_addr !== 8'h70 || o_rvalid1 !== 1'b0)
      $display("FAIL rmb_tie_to_0 gnt=%b%b addr=%h rv1=%b want 10/70/0",
               o_gnt0, o_gnt1, o_cash_addr, o_rvalid1);
    else n_pass++;
    tick();
    n_total++;
    if (o_rvalid0 !== 1'b1 || o_rvalid1 !== 1'b0 || o_rdata !== 8'hF0 || o_cash_ren !== 1'b0)
      $display("FAIL rmb_ret0 rv=%b%b rdata=%h ren=%b want 10/f0/0",
               o_rvalid0, o_rvalid1, o_rdata, o_cash_ren);
    else n_pass++;
    tick();
    n_total++;
    if (o_gnt1 !== 1'b1 || o_cash_addr !== 8'h78 || o_rvalid0 !== 1'b0)
      $display("FAIL rmb_then_1 gnt1=%b addr=%h rv0=%b want 1/78/0", o_gnt1, o_cash_addr, o_rvalid0);
    else n_pass++;
    tick();
    n_total++;
    if (o_rvalid1 !== 1'b1 || o_rdata !== 8'hF8)
      $display("FAIL rmb_ret1 rv1=%b rdata=%h want 1/f8", o_rvalid1, o_rdata);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    rst     = 1'b1;
    i_req0  = 1'b0;
    i_req1  = 1'b0;
    i_addr0 = 8'h00;
    i_addr1 = 8'h00;
    setup(0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_saturation();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
